uart_rx_oversampled: RTL

Asynchronous serial receiver: the receive end of the UART link whose transmitter runs from the selectable UART clock divider. Recovers 8N1 frames (optional even parity) from the `rx` pin using an internal 16x oversampling tick and per-baud divisors chosen by the same 2-bit `baud_sel` encoding. Presents each byte in a single-entry holding register with a valid/ack handshake to the core, and reports framing, parity and overrun errors.

---
 rtl/uart_rx_oversampled.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversampled.sv
// Purpose: 16x-oversampled UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with single-entry holding register.
// Latency: start edge to rx_valid = 3 + (154 [+16 parity]) * DIV + 1 clk cycles; divisor picked by baud_sel while idle.
// Backpressure: none on the line; a byte that completes while rx_valid is still high and unacked is dropped and sets overrun.
module uart_rx_oversampled #(
  parameter int unsigned DIV_SEL0 = 107,
  parameter int unsigned DIV_SEL1 = 53,
  parameter int unsigned DIV_SEL2 = 36,
  parameter int unsigned DIV_SEL3 = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] baud_sel,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t      state;
  logic        rx_meta;
  logic        rx_sync;
  logic        rx_prev;
  logic        start_edge;
  logic [15:0] div_q;
  logic [15:0] pcnt;
  logic        tick;
  logic [3:0]  tcnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        samp_a;
  logic        samp_b;
  logic        maj;
  logic        decide;
  logic        wrap;
  logic        done;
  logic        stop_bit;
`ifdef UART_RX_PARITY_EN
  logic        perr;
`endif

  // Oversample divisor for a given baud selection.
  function automatic logic [15:0] div_for(input logic [1:0] sel);
    logic [15:0] d;
    case (sel)
      2'b00:   d = 16'(DIV_SEL0);
      2'b01:   d = 16'(DIV_SEL1);
      2'b10:   d = 16'(DIV_SEL2);
      default: d = 16'(DIV_SEL3);
    endcase
    return d;
  endfunction

  // Two-flop synchronizer plus a third flop holding the previous line sample for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = rx_prev & ~rx_sync;

  // Oversample tick and bit-position decode; the tick-9 sample is taken live from rx_sync.
  assign tick   = (state != IDLE) && (pcnt == (div_q - 16'd1));
  assign decide = tick && (tcnt == 4'd9);
  assign wrap   = tick && (tcnt == 4'd15);
  assign maj    = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);

  // Receive FSM with prescaler, tick counter, majority sampling and data shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      div_q    <= 16'(DIV_SEL2);
      pcnt     <= 16'd0;
      tcnt     <= 4'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
      done     <= 1'b0;
      stop_bit <= 1'b1;
`ifdef UART_RX_PARITY_EN
      perr     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      if (state != IDLE) begin
        if (tick) begin
          pcnt <= 16'd0;
          tcnt <= tcnt + 4'd1;
        end else begin
          pcnt <= pcnt + 16'd1;
        end
      end

      if (tick && (tcnt == 4'd7)) samp_a <= rx_sync;
      if (tick && (tcnt == 4'd8)) samp_b <= rx_sync;

      case (state)
        IDLE: begin
          // Divisor only follows baud_sel between frames.
          div_q <= div_for(baud_sel);
          if (start_edge) begin
            state <= START;
            busy  <= 1'b1;
            pcnt  <= 16'd0;
            tcnt  <= 4'd0;
          end
        end

        START: begin
          if (decide && maj) begin
            // Line back high by mid-bit: glitch, not a start bit.
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wrap) begin
            state   <= DATA;
            bit_idx <= 3'd0;
          end
        end

        DATA: begin
          if (decide) shreg[bit_idx] <= maj;
          if (wrap) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          // Even parity: data bits plus parity bit must XOR to zero.
          if (decide) perr <= (^shreg) ^ maj;
          if (wrap) state <= STOP;
        end
`endif

        STOP: begin
          // Finish at mid-stop so a back-to-back start edge is never missed.
          if (decide) begin
            stop_bit <= maj;
            done     <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: ack clears, a completing frame loads unless an unread byte is still held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      if (done) begin
        if (!rx_valid || rx_ack) begin
          rx_data   <= shreg;
          frame_err <= ~stop_bit;
          rx_valid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
          parity_err <= perr;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule
